// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter.
// Result bundle, write source encoding and the x0 constant.
package wb_pkg;

  localparam int WB_XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LSU  = 2'd2
  } wb_src_t;

  typedef struct packed {
    logic [4:0]         addr;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests.
// Push is refused when full, pop is ignored when empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // power-of-two depth lets the pointers wrap by overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between ALU and LSU.
// Define WB_AGE_GUARD_EN to bound how long ALU results can starve.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int MAX_WAIT       = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_addr,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_addr,
  input  logic [XLEN-1:0] lsu_data,
  output logic            reg_wr_en,
  output logic [4:0]      reg_wr_addr,
  output logic [XLEN-1:0] reg_wr_data,
  output logic [1:0]      reg_wr_src,
  output logic            busy
);

  if (XLEN != WB_XLEN) begin : g_bad_xlen
    $error("XLEN must match wb_pkg::WB_XLEN");
  end
  if ((ALU_FIFO_DEPTH < 2) ||
      ((ALU_FIFO_DEPTH & (ALU_FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ALU_FIFO_DEPTH must be a power of two >= 2");
  end
  if (MAX_WAIT < 1) begin : g_bad_wait
    $error("MAX_WAIT must be at least 1");
  end

  wb_req_t fifo_din;
  wb_req_t fifo_dout;
  logic    fifo_full;
  logic    fifo_empty;
  logic    force_alu;
  logic    lsu_grant;
  logic    alu_grant;
  wb_req_t win_req;
  wb_src_t win_src;
  wb_src_t src_q;

  assign fifo_din  = '{addr: alu_addr, data: alu_data};
  assign alu_ready = !fifo_full;
  assign lsu_ready = !force_alu;
  assign lsu_grant = lsu_valid && !force_alu;
  assign alu_grant = !lsu_grant && !fifo_empty;
  assign busy      = !fifo_empty || lsu_valid;

  wb_fifo #(
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (alu_valid && alu_ready),
    .pop     (alu_grant),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef WB_AGE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;

  assign force_alu = !fifo_empty &&
                     (wait_cnt == WW'(MAX_WAIT));

  // counts LSU wins while an ALU result is waiting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (alu_grant) begin
      wait_cnt <= '0;
    end else if (lsu_grant && !fifo_empty &&
                 (wait_cnt != WW'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign force_alu = 1'b0;
`endif

  always_comb begin
    win_req = fifo_dout;
    win_src = WB_SRC_NONE;
    unique case (1'b1)
      lsu_grant: begin
        win_req = '{addr: lsu_addr, data: lsu_data};
        win_src = WB_SRC_LSU;
      end
      alu_grant: win_src = WB_SRC_ALU;
      default:   win_src = WB_SRC_NONE;
    endcase
  end

  // x0 writes are consumed but never strobed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      src_q       <= WB_SRC_NONE;
    end else begin
      src_q     <= win_src;
      reg_wr_en <= (win_src != WB_SRC_NONE) &&
                   (win_req.addr != REG_ZERO);
      if (win_src != WB_SRC_NONE) begin
        reg_wr_addr <= win_req.addr;
        reg_wr_data <= win_req.data;
      end
    end
  end

  assign reg_wr_src = src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter against a queue model.
// Honours WB_AGE_GUARD_EN in the reference model.
module tb_wb_port_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int MAXW  = 4;
`ifdef WB_AGE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_addr;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_addr;
  logic [XLEN-1:0] lsu_data;
  logic            reg_wr_en;
  logic [4:0]      reg_wr_addr;
  logic [XLEN-1:0] reg_wr_data;
  logic [1:0]      reg_wr_src;
  logic            busy;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN           (XLEN),
    .ALU_FIFO_DEPTH (DEPTH),
    .MAX_WAIT       (MAXW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_addr    (lsu_addr),
    .lsu_data    (lsu_data),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_src  (reg_wr_src),
    .busy        (busy)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          m_wait;
  logic        e_en;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic [1:0]  e_src;
  logic        last_ready;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wait = 0;
    e_en   = 1'b0;
    e_addr = '0;
    e_data = '0;
    e_src  = 2'd0;
  endtask

  task automatic check_wr();
    check("reg_wr_en",   32'(reg_wr_en),   32'(e_en));
    check("reg_wr_addr", 32'(reg_wr_addr), 32'(e_addr));
    check("reg_wr_data", reg_wr_data,      e_data);
    check("reg_wr_src",  32'(reg_wr_src),  32'(e_src));
  endtask

  // one clock cycle: drive, check handshakes, predict, check write port
  task automatic cycle(input logic av, input logic [4:0] aa,
                       input logic [31:0] ad, input logic lv,
                       input logic [4:0] la, input logic [31:0] ld);
    bit force_a, lwin, awin, had;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    #1;
    had        = (q.size() != 0);
    force_a    = GUARD && had && (m_wait == MAXW);
    last_ready = (q.size() < DEPTH);
    check("alu_ready", 32'(alu_ready), 32'(last_ready));
    check("lsu_ready", 32'(lsu_ready), 32'(!force_a));
    check("busy",      32'(busy),      32'(had || lv));
    lwin = lv && !force_a;
    awin = !lwin && had;
    if (lwin) begin
      e_src = 2'd2; e_addr = la; e_data = ld; e_en = (la != 5'd0);
    end else if (awin) begin
      e_src = 2'd1; e_addr = q[0].a; e_data = q[0].d;
      e_en = (q[0].a != 5'd0);
      void'(q.pop_front());
    end else begin
      e_src = 2'd0; e_en = 1'b0;
    end
    if (av && last_ready) q.push_back(ent_t'{aa, ad});
    if (awin) m_wait = 0;
    else if (lwin && had && m_wait < MAXW) m_wait++;
    @(posedge clk);
    #1;
    check_wr();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] vals [3];
    int k;
    vals = '{32'hA0, 32'hA1, 32'hA2};
    reset_n = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEAD;
    lsu_valid = 1'b0; lsu_addr = 5'd0; lsu_data = 32'd0;
    model_reset();
    #2;
    check_wr();
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // single ALU write, also first post-reset cycle
    cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    idle(3);

    // contention: LSU hogs the port while ALU pushes three results
    k = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(k < 3, 5'(10 + k), vals[k % 3], 1'b1, 5'd7, 32'h7000 + 32'(i));
      if (k < 3 && last_ready) k++;
    end
    for (int i = 0; i < 6; i++) begin
      cycle(k < 3, 5'(10 + k), vals[k % 3], 1'b0, 5'd0, 32'd0);
      if (k < 3 && last_ready) k++;
    end

    // x0 from the LSU is consumed without a strobe
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
    idle(1);

    // one queued ALU entry under a persistent LSU stream
    cycle(1'b1, 5'd9, 32'hAA, 1'b1, 5'd4, 32'h400);
    for (int i = 0; i < 7; i++)
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h401 + 32'(i));
    idle(3);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom,
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom);
    end
    idle(4);

    // reset while two ALU entries are queued
    cycle(1'b1, 5'd11, 32'hB0, 1'b1, 5'd3, 32'h300);
    cycle(1'b1, 5'd12, 32'hB1, 1'b1, 5'd3, 32'h301);
    check("fifo_full_pre_rst", 32'(alu_ready), 32'd0);
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_wr();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
